// File: rtl/ibuf_read_sched.sv
// ibuf read-side sequencer: walks a two-level loop of read addresses,
// issues one read per unstalled cycle, drains the forwarding chain, pulses done.
module ibuf_read_sched #(
    parameter int BUF_ADDR_WIDTH = 10,
    parameter int LOOP_ITER_W    = 16,
    parameter int ARRAY_N        = 1,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [BUF_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [BUF_ADDR_WIDTH-1:0] cfg_inner_stride,
    input  logic [LOOP_ITER_W-1:0]    cfg_inner_count,
    input  logic [BUF_ADDR_WIDTH-1:0] cfg_outer_stride,
    input  logic [LOOP_ITER_W-1:0]    cfg_outer_count,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      buf_read_req,
    output logic [BUF_ADDR_WIDTH-1:0] buf_read_addr
);

    localparam int D   = ARRAY_N - 1 + RD_LATENCY;
    localparam int DCW = $clog2(D) + 1;
    localparam logic [LOOP_ITER_W-1:0] ONE = LOOP_ITER_W'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                    state, nx;
    logic [BUF_ADDR_WIDTH-1:0] istr_q, ostr_q, addr_q, row_q;
    logic [LOOP_ITER_W-1:0]    icnt_q, ocnt_q, iidx_q, oidx_q;
    logic                      last_q, empty_q;
    logic [DCW-1:0]            drain_cnt;

    logic                      idle, cfg_empty, issue;
    logic                      inner_wrap, outer_last;
    logic                      empty_nx, busy_nx;
    logic [BUF_ADDR_WIDTH-1:0] c_istr, c_ostr, c_addr, c_row;
    logic [LOOP_ITER_W-1:0]    c_icnt, c_ocnt, c_iidx, c_oidx;

    // In the start cycle the loop walks straight off the cfg inputs so the
    // first request lands one cycle after start.
    assign idle      = (state == IDLE);
    assign cfg_empty = (cfg_inner_count == '0) || (cfg_outer_count == '0);
    assign c_istr    = idle ? cfg_inner_stride : istr_q;
    assign c_ostr    = idle ? cfg_outer_stride : ostr_q;
    assign c_icnt    = idle ? cfg_inner_count  : icnt_q;
    assign c_ocnt    = idle ? cfg_outer_count  : ocnt_q;
    assign c_addr    = idle ? cfg_base_addr    : addr_q;
    assign c_row     = idle ? cfg_base_addr    : row_q;
    assign c_iidx    = idle ? '0 : iidx_q;
    assign c_oidx    = idle ? '0 : oidx_q;

    assign inner_wrap = (c_iidx == c_icnt - ONE);
    assign outer_last = (c_oidx == c_ocnt - ONE);

    // Next state, issue decision and next values of the registered outputs.
    always_comb begin
        nx       = state;
        issue    = 1'b0;
        empty_nx = empty_q;
        unique case (state)
            IDLE: begin
                empty_nx = cfg_empty;
                if (start) begin
                    nx    = cfg_empty ? DRAIN : READ;
                    issue = !cfg_empty;
                end
            end
            READ: begin
                if (last_q) nx = DRAIN;
                else        issue = !stall;
            end
            DRAIN: if (drain_cnt == '0) nx = DONE;
            DONE:  nx = IDLE;
            default: nx = IDLE;
        endcase
        busy_nx = (nx == READ) || ((nx == DRAIN) && !empty_nx);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nx;
    end

    // Latched descriptor, loop indices and drain countdown.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            istr_q    <= '0;
            ostr_q    <= '0;
            icnt_q    <= '0;
            ocnt_q    <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            iidx_q    <= '0;
            oidx_q    <= '0;
            last_q    <= 1'b0;
            empty_q   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            if (idle && start) begin
                istr_q  <= cfg_inner_stride;
                ostr_q  <= cfg_outer_stride;
                icnt_q  <= cfg_inner_count;
                ocnt_q  <= cfg_outer_count;
                empty_q <= cfg_empty;
                last_q  <= 1'b0;
            end
            if (issue) begin
                if (inner_wrap) begin
                    iidx_q <= '0;
                    oidx_q <= c_oidx + ONE;
                    row_q  <= c_row + c_ostr;
                    addr_q <= c_row + c_ostr;
                    if (outer_last) last_q <= 1'b1;
                end else begin
                    iidx_q <= c_iidx + ONE;
                    oidx_q <= c_oidx;
                    row_q  <= c_row;
                    addr_q <= c_addr + c_istr;
                end
            end
            if (state != DRAIN && nx == DRAIN)
                drain_cnt <= empty_nx ? '0 : DCW'(D - 1);
            else if (state == DRAIN)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Registered outputs; the address holds while no request is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            buf_read_req  <= 1'b0;
            buf_read_addr <= '0;
        end else begin
            busy         <= busy_nx;
            done         <= (nx == DONE);
            buf_read_req <= issue;
            if (issue) buf_read_addr <= c_addr;
        end
    end

endmodule
